// File: rtl/mem_port1_sched.sv
// Purpose: arbitrates memory port 1 (A1 mux, W1 mux, WE1) between loader, fetch and load/store.
// Latency: write done 1 cycle after the sampling edge, read done 2 cycles after; one IDLE cycle between accesses.
// Backpressure: requests are levels held until done; requests seen outside IDLE wait for the next IDLE edge.
module mem_port1_sched #(
    parameter int WE_W     = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    input  logic             ls_req,
    input  logic [WE_W-1:0]  ls_we,
    input  logic             ext_req,
    input  logic [WE_W-1:0]  ext_we,
    output logic [SEL_W-1:0] A1_mux_control,
    output logic             W1_mux_control,
    output logic [WE_W-1:0]  WE1,
    output logic             pc_WE,
    output logic             old_pc_WE,
    output logic             fetch_gnt,
    output logic             ls_gnt,
    output logic             ext_gnt,
    output logic             fetch_done,
    output logic             ls_done,
    output logic             ext_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_EXT   = 2'd0,
        OWN_LS    = 2'd1,
        OWN_FETCH = 2'd2
    } owner_t;

    localparam logic [SEL_W-1:0] SEL_CU  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_ALU = SEL_W'(2);
    localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(MAX_WAIT);

    // Registered state; every output is driven straight from one of these.
    state_t           r_state;
    owner_t           r_owner;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [SEL_W-1:0] r_a1;
    logic             r_w1;
    logic [WE_W-1:0]  r_we1;
    logic             r_pc_we;
    logic [2:0]       r_gnt;    // {ext, ls, fetch}
    logic [2:0]       r_done;   // {ext, ls, fetch}
    logic             r_busy;

    // Next-state values.
    state_t           w_state_nxt;
    owner_t           w_owner_nxt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic [SEL_W-1:0] w_a1_nxt;
    logic             w_w1_nxt;
    logic [WE_W-1:0]  w_we1_nxt;
    logic             w_pc_we_nxt;
    logic [2:0]       w_gnt_nxt;
    logic [2:0]       w_done_nxt;
    logic             w_busy_nxt;

    logic             w_any_req;
    logic             w_fetch_forced;
    owner_t           w_winner;
    logic [2:0]       w_owner_onehot;

    // Arbitration: a starved fetch overrides the fixed ext > ls > fetch order.
    always_comb begin
        w_any_req      = ext_req | ls_req | fetch_req;
        w_fetch_forced = fetch_req && (r_wait_cnt == L_MAX);
        w_winner       = OWN_FETCH;
        if (w_fetch_forced) begin
            w_winner = OWN_FETCH;
        end else if (ext_req) begin
            w_winner = OWN_EXT;
        end else if (ls_req) begin
            w_winner = OWN_LS;
        end
    end

    // Current owner as a {ext, ls, fetch} one-hot, used for the read done pulse.
    always_comb begin
        w_owner_onehot = 3'b000;
        case (r_owner)
            OWN_EXT:   w_owner_onehot = 3'b100;
            OWN_LS:    w_owner_onehot = 3'b010;
            OWN_FETCH: w_owner_onehot = 3'b001;
            default:   w_owner_onehot = 3'b000;
        endcase
    end

    // Next-state and next-output logic; pulses default low, mux selects hold.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_wait_nxt  = r_wait_cnt;
        w_a1_nxt    = r_a1;
        w_w1_nxt    = r_w1;
        w_we1_nxt   = r_we1;
        w_pc_we_nxt = 1'b0;
        w_gnt_nxt   = 3'b000;
        w_done_nxt  = 3'b000;
        w_busy_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_a1_nxt  = SEL_PC;
                w_w1_nxt  = 1'b0;
                w_we1_nxt = '0;
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                    w_busy_nxt  = 1'b1;
                    w_owner_nxt = w_winner;
                    case (w_winner)
                        OWN_EXT: begin
                            w_a1_nxt      = SEL_CU;
                            w_w1_nxt      = 1'b1;
                            w_we1_nxt     = ext_we;
                            w_gnt_nxt[2]  = 1'b1;
                            w_done_nxt[2] = |ext_we;
                        end
                        OWN_LS: begin
                            w_a1_nxt      = SEL_ALU;
                            w_we1_nxt     = ls_we;
                            w_gnt_nxt[1]  = 1'b1;
                            w_done_nxt[1] = |ls_we;
                        end
                        default: begin
                            w_a1_nxt     = SEL_PC;
                            w_gnt_nxt[0] = 1'b1;
                        end
                    endcase
                    // Fetch starvation tracking: count only losses while fetch is asking.
                    if ((w_winner == OWN_FETCH) || !fetch_req) begin
                        w_wait_nxt = '0;
                    end else if (r_wait_cnt != L_MAX) begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end else begin
                    w_wait_nxt = '0;
                end
            end
            ST_ACCESS: begin
                if (|r_we1) begin
                    // Write already signalled done on entry; drop the strobes.
                    w_state_nxt = ST_IDLE;
                    w_a1_nxt    = SEL_PC;
                    w_w1_nxt    = 1'b0;
                    w_we1_nxt   = '0;
                end else begin
                    // Keep the address steady so the synchronous read lands on R1.
                    w_state_nxt = ST_RDATA;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = w_owner_onehot;
                    w_pc_we_nxt = (r_owner == OWN_FETCH);
                end
            end
            ST_RDATA: begin
                w_state_nxt = ST_IDLE;
                w_a1_nxt    = SEL_PC;
                w_w1_nxt    = 1'b0;
                w_we1_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_a1_nxt    = SEL_PC;
                w_w1_nxt    = 1'b0;
                w_we1_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_FETCH;
            r_wait_cnt <= '0;
            r_a1       <= SEL_PC;
            r_w1       <= 1'b0;
            r_we1      <= '0;
            r_pc_we    <= 1'b0;
            r_gnt      <= 3'b000;
            r_done     <= 3'b000;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_a1       <= w_a1_nxt;
            r_w1       <= w_w1_nxt;
            r_we1      <= w_we1_nxt;
            r_pc_we    <= w_pc_we_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign A1_mux_control = r_a1;
    assign W1_mux_control = r_w1;
    assign WE1            = r_we1;
    assign pc_WE          = r_pc_we;
    assign old_pc_WE      = r_pc_we;
    assign ext_gnt        = r_gnt[2];
    assign ls_gnt         = r_gnt[1];
    assign fetch_gnt      = r_gnt[0];
    assign ext_done       = r_done[2];
    assign ls_done        = r_done[1];
    assign fetch_done     = r_done[0];
    assign busy           = r_busy;

endmodule

// File: tb/tb_mem_port1_sched.sv
// Purpose: directed bench for mem_port1_sched with a transaction-level output model.
// Latency: model predicts each registered output for the cycle after every rising edge.
// Backpressure: requests are held or dropped by the directed sequence; no flow control in the bench.
module tb_mem_port1_sched;

    logic       clk;
    logic       rst;
    logic       fetch_req;
    logic       ls_req;
    logic [3:0] ls_we;
    logic       ext_req;
    logic [3:0] ext_we;
    logic [1:0] A1_mux_control;
    logic       W1_mux_control;
    logic [3:0] WE1;
    logic       pc_WE;
    logic       old_pc_WE;
    logic       fetch_gnt;
    logic       ls_gnt;
    logic       ext_gnt;
    logic       fetch_done;
    logic       ls_done;
    logic       ext_done;
    logic       busy;

    int n_chk;
    int n_fail;

    mem_port1_sched #(
        .WE_W(4), .SEL_W(2), .CNT_W(4), .MAX_WAIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .ls_req(ls_req), .ls_we(ls_we),
        .ext_req(ext_req), .ext_we(ext_we),
        .A1_mux_control(A1_mux_control), .W1_mux_control(W1_mux_control),
        .WE1(WE1), .pc_WE(pc_WE), .old_pc_WE(old_pc_WE),
        .fetch_gnt(fetch_gnt), .ls_gnt(ls_gnt), .ext_gnt(ext_gnt),
        .fetch_done(fetch_done), .ls_done(ls_done), .ext_done(ext_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle; gnt/done are ordered {ext, ls, fetch}.
    typedef struct packed {
        logic [1:0] sel;
        logic       w1;
        logic [3:0] we;
        logic       pc;
        logic       opc;
        logic [2:0] gnt;
        logic [2:0] done;
        logic       busy;
    } obs_t;

    obs_t dut_o;
    always_comb begin
        dut_o.sel  = A1_mux_control;
        dut_o.w1   = W1_mux_control;
        dut_o.we   = WE1;
        dut_o.pc   = pc_WE;
        dut_o.opc  = old_pc_WE;
        dut_o.gnt  = {ext_gnt, ls_gnt, fetch_gnt};
        dut_o.done = {ext_done, ls_done, fetch_done};
        dut_o.busy = busy;
    end

    function automatic obs_t idle_o();
        obs_t o;
        o = '0;
        o.sel = 2'd1;
        return o;
    endfunction

    // Model: each transaction is a scripted list of per-cycle outputs, ending in one idle gap cycle.
    obs_t exp_o;
    obs_t plan_q[$];
    int   wcnt;
    int   who;      // 0 none, 1 ext, 2 ls, 3 fetch
    obs_t acc_o;
    obs_t rd_o;
    bit   model_valid;

    // Advance the model on each rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        model_valid = 1'b1;
        if (!rst) begin
            plan_q.delete();
            wcnt  = 0;
            exp_o = idle_o();
        end else if (plan_q.size() > 0) begin
            exp_o = plan_q.pop_front();
        end else begin
            if (fetch_req && wcnt == 8) who = 3;
            else if (ext_req)           who = 1;
            else if (ls_req)            who = 2;
            else if (fetch_req)         who = 3;
            else                        who = 0;

            if (who == 3 || !fetch_req) wcnt = 0;
            else if (wcnt < 8)          wcnt = wcnt + 1;

            if (who == 0) begin
                exp_o = idle_o();
            end else begin
                acc_o = '0;
                acc_o.busy = 1'b1;
                if (who == 1) begin
                    acc_o.sel = 2'd0; acc_o.w1 = 1'b1; acc_o.we = ext_we; acc_o.gnt = 3'b100;
                end else if (who == 2) begin
                    acc_o.sel = 2'd2; acc_o.we = ls_we; acc_o.gnt = 3'b010;
                end else begin
                    acc_o.sel = 2'd1; acc_o.gnt = 3'b001;
                end
                if (acc_o.we != 4'd0) begin
                    acc_o.done = acc_o.gnt;
                    exp_o = acc_o;
                    plan_q.push_back(idle_o());
                end else begin
                    rd_o      = acc_o;
                    rd_o.gnt  = 3'b000;
                    rd_o.done = acc_o.gnt;
                    rd_o.pc   = (who == 3);
                    rd_o.opc  = (who == 3);
                    exp_o = acc_o;
                    plan_q.push_back(rd_o);
                    plan_q.push_back(idle_o());
                end
            end
        end
    end

    // Every-cycle comparison of the whole output bundle against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            n_chk++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, dut_o, exp_o);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; fetch_req = 1'b0; ls_req = 1'b0; ls_we = 4'd0;
        ext_req = 1'b0; ext_we = 4'd0;
        repeat (3) step();
        check("reset_a1", A1_mux_control, 1);
        check("reset_busy", busy, 0);
        check("reset_we1", WE1, 0);
        check("reset_pcwe", pc_WE, 0);

        // Fetch read from reset release.
        rst = 1'b1; fetch_req = 1'b1;
        step();
        check("t1_fetch_gnt", fetch_gnt, 1);
        check("t1_a1", A1_mux_control, 1);
        check("t1_we1", WE1, 0);
        step();
        check("t1_fetch_done", fetch_done, 1);
        check("t1_pc_we", pc_WE, 1);
        check("t1_old_pc_we", old_pc_WE, 1);
        fetch_req = 1'b0;
        step();
        check("t1_busy_clear", busy, 0);

        // Load/store full-word write: single ACCESS cycle.
        ls_req = 1'b1; ls_we = 4'hF;
        step();
        check("t2_ls_gnt", ls_gnt, 1);
        check("t2_ls_done", ls_done, 1);
        check("t2_a1", A1_mux_control, 2);
        check("t2_we1", WE1, 4'hF);
        check("t2_w1", W1_mux_control, 0);
        ls_req = 1'b0;
        step();
        check("t2_no_rdata_busy", busy, 0);
        check("t2_no_rdata_done", ls_done, 0);

        // All three at once: ext read, then ls write, then fetch.
        ext_req = 1'b1; ext_we = 4'd0; ls_req = 1'b1; ls_we = 4'hF; fetch_req = 1'b1;
        step();
        check("t3_ext_gnt", ext_gnt, 1);
        check("t3_ext_a1", A1_mux_control, 0);
        check("t3_ext_w1", W1_mux_control, 1);
        step();
        check("t3_ext_done", ext_done, 1);
        ext_req = 1'b0;
        step();
        step();
        check("t3_ls_gnt", ls_gnt, 1);
        ls_req = 1'b0;
        step();
        step();
        check("t3_fetch_gnt", fetch_gnt, 1);
        step();
        check("t3_fetch_done", fetch_done, 1);
        fetch_req = 1'b0;
        step();

        // Fetch starvation: eight ls wins, then fetch forced through.
        ls_req = 1'b1; ls_we = 4'b0011; fetch_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t4_ls_wins", ls_gnt, 1);
            check("t4_ls_we", WE1, 4'b0011);
            step();
        end
        step();
        check("t4_fetch_forced", fetch_gnt, 1);
        step();
        check("t4_fetch_done", fetch_done, 1);
        step();
        step();
        check("t4_counter_cleared", ls_gnt, 1);
        ls_req = 1'b0; fetch_req = 1'b0;
        step();
        step();

        // Reset while a fetch read is in flight.
        fetch_req = 1'b1;
        step();
        check("t5_fetch_gnt", fetch_gnt, 1);
        rst = 1'b0;
        step();
        check("t5_no_done", fetch_done, 0);
        check("t5_no_pcwe", pc_WE, 0);
        check("t5_a1_reset", A1_mux_control, 1);
        check("t5_busy_reset", busy, 0);
        rst = 1'b1; fetch_req = 1'b0;
        step();
        check("t5_still_idle", busy, 0);

        // Fetch request dropped right after grant still completes once.
        fetch_req = 1'b1;
        step();
        check("t6_fetch_gnt", fetch_gnt, 1);
        fetch_req = 1'b0;
        step();
        check("t6_fetch_done", fetch_done, 1);
        check("t6_pc_we", pc_WE, 1);
        step();
        step();
        check("t6_no_regrant", fetch_gnt, 0);
        check("t6_no_redone", fetch_done, 0);

        // External loader partial write steers W1 to R2.
        ext_req = 1'b1; ext_we = 4'b0101;
        step();
        check("t7_ext_done", ext_done, 1);
        check("t7_we1", WE1, 4'b0101);
        check("t7_w1", W1_mux_control, 1);
        ext_req = 1'b0;
        step();
        check("t7_we1_clear", WE1, 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
